int_sop_accum_n: RTL and testbench

- Parametrised N-lane integer sum-of-products accumulator for the DSP-heavy fabric.
- Generalises the fixed 4-lane 9x9 sum-of-products accumulate block in three ways: lane count and operand/accumulator widths are configurable; signed or unsigned mode is selected per dot product; saturation is optional and raises a sticky overflow flag.
- Sits between weight/activation SRAM readers and LSTM gate logic. Cascades vertically through chainin/chainout.

---
 rtl/int_sop_accum_n.sv | 146 ++++++++++++++
 tb/tb_int_sop_accum_n.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_sop_accum_n.sv
// N-lane integer sum-of-products accumulator with optional saturation and a cascade chain.
// Three fixed stages: operand capture, lane products, accumulate with range check.
module int_sop_accum_n #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned A_W      = 9,
  parameter int unsigned B_W      = 9,
  parameter int unsigned ACC_W    = 64,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   acc_clear,
  input  logic                   acc_last,
  input  logic                   signed_mode,
  input  logic                   chain_en,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*B_W-1:0]   b,
  input  logic [ACC_W-1:0]       chainin,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       result,
  output logic [ACC_W-1:0]       chainout,
  output logic                   overflow
);

  localparam int unsigned EW = ACC_W + 2;
  localparam int unsigned PW = A_W + B_W + 2;

  if (ACC_W < A_W + B_W + $clog2(LANES)) begin : g_width_check
    $error("ACC_W too narrow for A_W + B_W + clog2(LANES)");
  end

  // Group mode is latched as clear beats enter, so every beat carries its own mode downstream.
  logic mode_q;
  logic in_signed;
  assign in_signed = acc_clear ? signed_mode : mode_q;

  logic                 s1_valid, s1_clear, s1_last, s1_signed, s1_chain_en;
  logic [LANES*A_W-1:0] s1_a;
  logic [LANES*B_W-1:0] s1_b;
  logic [ACC_W-1:0]     s1_chainin;

  logic                 s2_valid, s2_clear, s2_last, s2_signed, s2_chain_en;
  logic [ACC_W-1:0]     s2_chainin;
  logic signed [EW-1:0] s2_prod [LANES];
  logic signed [EW-1:0] prod_d  [LANES];

  logic [ACC_W-1:0] acc_q;
  logic             sticky_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic signed [A_W:0]  ax;
      logic signed [B_W:0]  bx;
      logic signed [PW-1:0] p;
      ax = {s1_signed & s1_a[i*A_W + A_W - 1], s1_a[i*A_W +: A_W]};
      bx = {s1_signed & s1_b[i*B_W + B_W - 1], s1_b[i*B_W +: B_W]};
      p = PW'(ax) * PW'(bx);
      prod_d[i] = EW'(p);
    end
  end

  logic signed [EW-1:0] lane_sum, acc_ext, chain_ext, base, raw;
  logic [ACC_W-1:0]     sat_val, acc_next;
  logic                 ovf, sticky_next;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + s2_prod[i];
    end
    acc_ext   = s2_signed ? {{2{acc_q[ACC_W-1]}}, acc_q} : {2'b00, acc_q};
    chain_ext = s2_signed ? {{2{s2_chainin[ACC_W-1]}}, s2_chainin} : {2'b00, s2_chainin};
    base      = s2_clear ? (s2_chain_en ? chain_ext : '0) : acc_ext;
    raw       = base + lane_sum;
    if (s2_signed) begin
      // In range only when the guard bits all match the result sign bit.
      ovf     = !((&raw[EW-1:ACC_W-1]) || !(|raw[EW-1:ACC_W-1]));
      sat_val = raw[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf     = |raw[EW-1:ACC_W];
      sat_val = raw[EW-1] ? '0 : '1;
    end
    acc_next    = (ovf && SATURATE) ? sat_val : raw[ACC_W-1:0];
    sticky_next = s2_clear ? ovf : (sticky_q | ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= 1'b1;
      s1_valid    <= 1'b0;
      s1_clear    <= 1'b0;
      s1_last     <= 1'b0;
      s1_signed   <= 1'b1;
      s1_chain_en <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_chainin  <= '0;
      s2_valid    <= 1'b0;
      s2_clear    <= 1'b0;
      s2_last     <= 1'b0;
      s2_signed   <= 1'b1;
      s2_chain_en <= 1'b0;
      s2_chainin  <= '0;
      s2_prod     <= '{default: '0};
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (in_valid && acc_clear) mode_q <= signed_mode;
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_clear    <= acc_clear;
        s1_last     <= acc_last;
        s1_signed   <= in_signed;
        s1_chain_en <= chain_en;
        s1_a        <= a;
        s1_b        <= b;
        s1_chainin  <= chainin;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_clear    <= s1_clear;
        s2_last     <= s1_last;
        s2_signed   <= s1_signed;
        s2_chain_en <= s1_chain_en;
        s2_chainin  <= s1_chainin;
        s2_prod     <= prod_d;
      end
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        acc_q    <= acc_next;
        sticky_q <= sticky_next;
        if (s2_last) begin
          result   <= acc_next;
          overflow <= sticky_next;
        end
      end
    end
  end

  assign chainout = acc_q;

endmodule

// File: tb/tb_int_sop_accum_n.sv
// Bench for int_sop_accum_n: three instances (32-bit saturating, 20-bit saturating, 20-bit
// wrapping) share stimulus and are compared each cycle against an arithmetic reference model.
module tb_int_sop_accum_n;

  localparam int NK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, acc_clear, acc_last, signed_mode, chain_en;
  logic [35:0] a, b;
  logic [31:0] chainin;
  logic        ov0, ov1, ov2, of0, of1, of2;
  logic [31:0] res0, co0;
  logic [19:0] res1, co1, res2, co2;

  int_sop_accum_n #(.LANES(4), .A_W(9), .B_W(9), .ACC_W(32), .SATURATE(1'b1)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_clear(acc_clear),
    .acc_last(acc_last), .signed_mode(signed_mode), .chain_en(chain_en), .a(a), .b(b),
    .chainin(chainin), .out_valid(ov0), .result(res0), .chainout(co0), .overflow(of0)
  );
  int_sop_accum_n #(.LANES(4), .A_W(9), .B_W(9), .ACC_W(20), .SATURATE(1'b1)) u_w20s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_clear(acc_clear),
    .acc_last(acc_last), .signed_mode(signed_mode), .chain_en(chain_en), .a(a), .b(b),
    .chainin(chainin[19:0]), .out_valid(ov1), .result(res1), .chainout(co1), .overflow(of1)
  );
  int_sop_accum_n #(.LANES(4), .A_W(9), .B_W(9), .ACC_W(20), .SATURATE(1'b0)) u_w20w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_clear(acc_clear),
    .acc_last(acc_last), .signed_mode(signed_mode), .chain_en(chain_en), .a(a), .b(b),
    .chainin(chainin[19:0]), .out_valid(ov2), .result(res2), .chainout(co2), .overflow(of2)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: accumulator bit pattern, group mode, sticky flag per instance.
  longint m_acc [NK];
  bit     m_mode[NK];
  bit     m_stk [NK];
  // Two-deep delay line: a beat becomes visible two steps after it is issued.
  bit     p_v   [2];
  bit     p_last[2];
  longint p_acc [2][NK];
  bit     p_stk [2][NK];
  longint e_chain[NK], e_res[NK];
  bit     e_ov[NK], e_ovf[NK];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(longint v, int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  function automatic logic [35:0] pk(int x0, int x1, int x2, int x3);
    logic [35:0] r;
    r[8:0] = x0[8:0]; r[17:9] = x1[8:0]; r[26:18] = x2[8:0]; r[35:27] = x3[8:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_acc[k] = 0; m_mode[k] = 1'b1; m_stk[k] = 1'b0;
      e_chain[k] = 0; e_res[k] = 0; e_ov[k] = 1'b0; e_ovf[k] = 1'b0;
    end
    for (int j = 0; j < 2; j++) begin
      p_v[j] = 1'b0; p_last[j] = 1'b0;
    end
  endtask

  task automatic step(bit rst, bit v, bit clr, bit lst, bit sgn, bit ce,
                      logic [35:0] av, logic [35:0] bv, logic [31:0] ch);
    bit     r_v;
    longint r_acc[NK];
    bit     r_stk[NK];
    reset = rst; in_valid = v; acc_clear = clr; acc_last = lst;
    signed_mode = sgn; chain_en = ce; a = av; b = bv; chainin = ch;
    r_v = v && !rst;
    for (int k = 0; k < NK; k++) begin
      int     w;
      longint mask, base, sum, raw, lo, hi, val;
      bit     md, o;
      r_acc[k] = 0; r_stk[k] = 1'b0;
      if (r_v) begin
        w    = (k == 0) ? 32 : 20;
        mask = (longint'(1) << w) - 1;
        md   = clr ? sgn : m_mode[k];
        base = clr ? (ce ? (longint'(ch) & mask) : 0) : m_acc[k];
        if (md) base = sx(base, w);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
          longint x, y;
          x = longint'(av[i*9 +: 9]);
          y = longint'(bv[i*9 +: 9]);
          if (md) begin
            x = sx(x, 9); y = sx(y, 9);
          end
          sum += x * y;
        end
        raw = base + sum;
        lo  = md ? -(longint'(1) << (w - 1)) : 0;
        hi  = md ? (longint'(1) << (w - 1)) - 1 : mask;
        o   = (raw < lo) || (raw > hi);
        val = raw;
        if (o && k != 2) val = (raw < lo) ? lo : hi;
        m_acc[k]  = val & mask;
        m_stk[k]  = clr ? o : (m_stk[k] | o);
        m_mode[k] = md;
        r_acc[k]  = m_acc[k];
        r_stk[k]  = m_stk[k];
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NK; k++) begin
        e_ov[k] = 1'b0;
        if (p_v[1]) begin
          e_chain[k] = p_acc[1][k];
          if (p_last[1]) begin
            e_ov[k] = 1'b1; e_res[k] = p_acc[1][k]; e_ovf[k] = p_stk[1][k];
          end
        end
      end
      p_v[1] = p_v[0]; p_last[1] = p_last[0];
      p_v[0] = r_v;    p_last[0] = lst;
      for (int k = 0; k < NK; k++) begin
        p_acc[1][k] = p_acc[0][k]; p_stk[1][k] = p_stk[0][k];
        p_acc[0][k] = r_acc[k];    p_stk[0][k] = r_stk[k];
      end
    end
    check("out_valid_w32", 64'(ov0), 64'(e_ov[0]));
    check("result_w32", 64'(res0), e_chain[0] * 0 + e_res[0]);
    check("chainout_w32", 64'(co0), e_chain[0]);
    check("overflow_w32", 64'(of0), 64'(e_ovf[0]));
    check("out_valid_w20s", 64'(ov1), 64'(e_ov[1]));
    check("result_w20s", 64'(res1), e_res[1]);
    check("chainout_w20s", 64'(co1), e_chain[1]);
    check("overflow_w20s", 64'(of1), 64'(e_ovf[1]));
    check("out_valid_w20w", 64'(ov2), 64'(e_ov[2]));
    check("result_w20w", 64'(res2), e_res[2]);
    check("chainout_w20w", 64'(co2), e_chain[2]);
    check("overflow_w20w", 64'(of2), 64'(e_ovf[2]));
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(1);

    // Single signed beat: 1*5 + 2*6 + 3*7 + 4*8.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0);
    idle(4);
    check("t1_result", 64'(res0), 64'd70);

    // Three beats of ones with a bubble before the last.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0);
    idle(4);
    check("t2_result", 64'(res0), 64'd12);

    // Signed extremes.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(-256, -256, -256, -256),
         pk(-256, -256, -256, -256), '0);
    idle(4);
    check("t3_pos", 64'(res0), 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(-256, -256, -256, -256),
         pk(255, 255, 255, 255), '0);
    idle(4);
    check("t3_neg", 64'(res0), 64'hFFFC0400);

    // Signed saturation on the 20-bit instances, then a clean group.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pk(-256, -256, -256, -256),
         pk(-256, -256, -256, -256), '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(-256, -256, -256, -256),
         pk(-256, -256, -256, -256), '0);
    idle(4);
    check("t4_clamp", 64'(res1), 64'd524287);
    check("t4_ovf", 64'(of1), 64'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    idle(4);
    check("t4_clear", 64'(res1), 64'd0);
    check("t4_ovf_clear", 64'(of1), 64'd0);

    // Unsigned 511*511 lanes: one beat fits, two beats clamp or wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pk(511, 511, 511, 511), pk(511, 511, 511, 511), '0);
    idle(4);
    check("t5_one", 64'(res1), 64'd1044484);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(511, 511, 511, 511), pk(511, 511, 511, 511), '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(511, 511, 511, 511), pk(511, 511, 511, 511), '0);
    idle(4);
    check("t5_sat", 64'(res1), 64'd1048575);
    check("t5_wrap", 64'(res2), 64'd1040392);
    check("t5_wrap_ovf", 64'(of2), 64'd1);

    // Cascade seed, then reset while a group is in flight.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 32'd1000);
    idle(4);
    check("t6_chain", 64'(res0), 64'd1070);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(5);
    check("t6_res_zero", 64'(res0), 64'd0);
    check("t6_chain_zero", 64'(co0), 64'd0);

    // Random traffic: bubbles, mixed modes, chain seeds and occasional resets.
    repeat (400) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ra[35:0], rb[35:0], $urandom);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
